// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - per-thread run-state tracker with round-robin issue arbitration
module thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int MEM_LAT     = 8,
    parameter logic [NUM_THREADS-1:0] INIT_MASK = {NUM_THREADS{1'b1}},
    localparam int BT = $clog2(NUM_THREADS),
    localparam int TW = $clog2(MEM_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start_valid,
    input  logic [BT-1:0]          start_tid,
    input  logic                   stall_valid,
    input  logic [BT-1:0]          stall_tid,
    input  logic                   wake_valid,
    input  logic [BT-1:0]          wake_tid,
    input  logic                   halt_valid,
    input  logic [BT-1:0]          halt_tid,
    output logic                   issue_valid,
    output logic [BT-1:0]          issue_tid,
    output logic [NUM_THREADS-1:0] ready_mask,
    output logic [NUM_THREADS-1:0] stall_mask,
    output logic                   all_off
);

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_READY   = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    logic [1:0]             r_state [NUM_THREADS];
    logic [TW-1:0]          r_timer [NUM_THREADS];
    logic [BT-1:0]          r_last;
    logic                   r_issue_valid;
    logic [BT-1:0]          r_issue_tid;
    logic [NUM_THREADS-1:0] r_ready_mask;
    logic [NUM_THREADS-1:0] r_stall_mask;
    logic                   r_all_off;

    logic [1:0]             w_state_nxt [NUM_THREADS];
    logic [TW-1:0]          w_timer_nxt [NUM_THREADS];
    logic [NUM_THREADS-1:0] w_halt_hit;
    logic [NUM_THREADS-1:0] w_stall_hit;
    logic [NUM_THREADS-1:0] w_wake_hit;
    logic [NUM_THREADS-1:0] w_start_hit;
    logic [NUM_THREADS-1:0] w_eligible;
    logic [NUM_THREADS-1:0] w_ready_nxt;
    logic [NUM_THREADS-1:0] w_stall_nxt;
    logic [BT-1:0]          w_winner;
    logic [BT-1:0]          w_idx;
    logic                   w_found;

    // Per-thread next state; the if-chain order encodes halt > stall > wake/timeout > start.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_halt_hit[i]  = halt_valid  && (halt_tid  == BT'(i));
            w_stall_hit[i] = stall_valid && (stall_tid == BT'(i));
            w_wake_hit[i]  = wake_valid  && (wake_tid  == BT'(i));
            w_start_hit[i] = start_valid && (start_tid == BT'(i));
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            if (w_halt_hit[i]) begin
                w_state_nxt[i] = ST_OFF;
                w_timer_nxt[i] = '0;
            end else if (r_state[i] == ST_READY) begin
                if (w_stall_hit[i]) begin
                    w_state_nxt[i] = ST_STALLED;
                    w_timer_nxt[i] = TW'(MEM_LAT);
                end
            end else if (r_state[i] == ST_STALLED) begin
                if (w_wake_hit[i] || (r_timer[i] == TW'(1))) begin
                    w_state_nxt[i] = ST_READY;
                    w_timer_nxt[i] = '0;
                end else if (r_timer[i] != '0) begin
                    w_timer_nxt[i] = r_timer[i] - TW'(1);
                end
            end else if (r_state[i] == ST_OFF) begin
                if (w_start_hit[i]) begin
                    w_state_nxt[i] = ST_READY;
                end
            end
            w_ready_nxt[i] = (w_state_nxt[i] == ST_READY);
            w_stall_nxt[i] = (w_state_nxt[i] == ST_STALLED);
            w_eligible[i]  = (r_state[i] == ST_READY) && !w_halt_hit[i] && !w_stall_hit[i];
        end
    end

    // Round-robin search starting just after the last issued thread; index wraps in BT bits.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = r_last;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            w_idx = r_last + BT'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_state[i] <= INIT_MASK[i] ? ST_READY : ST_OFF;
                r_timer[i] <= '0;
            end
            r_last        <= BT'(NUM_THREADS - 1);
            r_issue_valid <= 1'b0;
            r_issue_tid   <= '0;
            r_ready_mask  <= INIT_MASK;
            r_stall_mask  <= '0;
            r_all_off     <= (INIT_MASK == '0);
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            if (en && w_found) begin
                r_issue_valid <= 1'b1;
                r_issue_tid   <= w_winner;
                r_last        <= w_winner;
            end else begin
                r_issue_valid <= 1'b0;
            end
            r_ready_mask <= w_ready_nxt;
            r_stall_mask <= w_stall_nxt;
            r_all_off    <= ~|(w_ready_nxt | w_stall_nxt);
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_tid   = r_issue_tid;
    assign ready_mask  = r_ready_mask;
    assign stall_mask  = r_stall_mask;
    assign all_off     = r_all_off;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - directed bench with reference-model scoreboard for thread_scheduler
module tb_thread_scheduler;

    localparam int NT = 4;
    localparam int ML = 8;

    typedef struct packed {
        logic          iv;
        logic [1:0]    it;
        logic [NT-1:0] rm;
        logic [NT-1:0] sm;
        logic          ao;
    } exp_t;

    localparam logic [11:0] RESET_VEC = 12'b0_00_1111_0000_0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          start_valid = 1'b0;
    logic [1:0]    start_tid = '0;
    logic          stall_valid = 1'b0;
    logic [1:0]    stall_tid = '0;
    logic          wake_valid = 1'b0;
    logic [1:0]    wake_tid = '0;
    logic          halt_valid = 1'b0;
    logic [1:0]    halt_tid = '0;
    logic          issue_valid;
    logic [1:0]    issue_tid;
    logic [NT-1:0] ready_mask;
    logic [NT-1:0] stall_mask;
    logic          all_off;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    // Reference model: 0 off, 1 ready, 2 stalled; a stall records the edge it expires on.
    int         m_state [NT];
    int         m_due [NT];
    int         m_last;
    int         cyc = 0;
    logic       m_iv;
    logic [1:0] m_it;

    always #5 clk = ~clk;

    thread_scheduler #(
        .NUM_THREADS(NT),
        .MEM_LAT(ML),
        .INIT_MASK(4'b1111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .start_valid(start_valid),
        .start_tid(start_tid),
        .stall_valid(stall_valid),
        .stall_tid(stall_tid),
        .wake_valid(wake_valid),
        .wake_tid(wake_tid),
        .halt_valid(halt_valid),
        .halt_tid(halt_tid),
        .issue_valid(issue_valid),
        .issue_tid(issue_tid),
        .ready_mask(ready_mask),
        .stall_mask(stall_mask),
        .all_off(all_off)
    );

    function automatic logic [11:0] observed();
        return {issue_valid, issue_tid, ready_mask, stall_mask, all_off};
    endfunction

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.iv = m_iv;
        e.it = m_it;
        e.ao = 1'b1;
        for (int i = 0; i < NT; i++) begin
            e.rm[i] = (m_state[i] == 1);
            e.sm[i] = (m_state[i] == 2);
            if (m_state[i] != 0) e.ao = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_state[i] = 1;
            m_due[i]   = 0;
        end
        m_last = NT - 1;
        m_iv   = 1'b0;
        m_it   = 2'd0;
    endtask

    task automatic step(string tag);
        logic [NT-1:0] elig;
        bit            found;
        int            w;
        int            t;
        bit            hh, sh, wh, sth;
        elig = '0;
        for (int i = 0; i < NT; i++) begin
            hh = halt_valid && (int'(halt_tid) == i);
            sh = stall_valid && (int'(stall_tid) == i);
            elig[i] = (m_state[i] == 1) && !hh && !sh;
        end
        found = 0;
        w = 0;
        for (int k = 1; k <= NT; k++) begin
            t = (m_last + k) % NT;
            if (!found && elig[t]) begin
                found = 1;
                w = t;
            end
        end
        if (en && found) begin
            m_iv = 1'b1;
            m_it = w[1:0];
            m_last = w;
        end else begin
            m_iv = 1'b0;
        end
        cyc++;
        for (int i = 0; i < NT; i++) begin
            hh  = halt_valid  && (int'(halt_tid)  == i);
            sh  = stall_valid && (int'(stall_tid) == i);
            wh  = wake_valid  && (int'(wake_tid)  == i);
            sth = start_valid && (int'(start_tid) == i);
            if (hh) m_state[i] = 0;
            else if (m_state[i] == 1 && sh) begin
                m_state[i] = 2;
                m_due[i]   = cyc + ML;
            end else if (m_state[i] == 2 && (wh || cyc == m_due[i])) m_state[i] = 1;
            else if (m_state[i] == 0 && sth) m_state[i] = 1;
        end
        q.push_back(model_out());
        @(posedge clk);
        #1;
        check(tag, observed(), q.pop_front());
        start_valid = 1'b0;
        stall_valid = 1'b0;
        wake_valid  = 1'b0;
        halt_valid  = 1'b0;
    endtask

    initial begin
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", observed(), RESET_VEC);
        #3;
        rst = 1'b1;
        model_reset();

        // Full round robin from reset.
        for (int i = 0; i < 6; i++) begin
            step("t1_rr");
            check("t1_tid", {10'd0, issue_tid}, 12'(i % NT));
        end

        // Stall tid 1 for MEM_LAT edges.
        stall_valid = 1'b1; stall_tid = 2'd1;
        step("t2_stall");
        check("t2_smask_set", {11'd0, stall_mask[1]}, 12'd1);
        for (int j = 1; j <= ML; j++) begin
            step("t2_run");
            check("t2_smask", {11'd0, stall_mask[1]}, (j < ML) ? 12'd1 : 12'd0);
        end
        repeat (4) step("t2_after");

        // Stall tid 2, wake it early.
        stall_valid = 1'b1; stall_tid = 2'd2;
        step("t3_stall");
        repeat (2) step("t3_wait");
        wake_valid = 1'b1; wake_tid = 2'd2;
        step("t3_wake");
        check("t3_ready2", {11'd0, ready_mask[2]}, 12'd1);
        repeat (4) step("t3_after");

        // Halt beats stall on the same tid; restart later.
        halt_valid = 1'b1; halt_tid = 2'd3;
        stall_valid = 1'b1; stall_tid = 2'd3;
        step("t4_halt_stall");
        check("t4_off3", {10'd0, ready_mask[3], stall_mask[3]}, 12'd0);
        repeat (4) step("t4_off");
        start_valid = 1'b1; start_tid = 2'd3;
        step("t4_start");
        repeat (5) step("t4_after");

        // Issue enable low: no issue, FSMs keep running.
        en = 1'b0;
        stall_valid = 1'b1; stall_tid = 2'd0;
        step("en_low");
        step("en_low2");
        en = 1'b1;
        repeat (ML) step("en_back");

        // Stall every thread, then halt every thread.
        for (int i = 0; i < NT; i++) begin
            stall_valid = 1'b1; stall_tid = 2'(i);
            step("t5_stall_all");
        end
        repeat (ML) step("t5_wait");
        for (int i = 0; i < NT; i++) begin
            halt_valid = 1'b1; halt_tid = 2'(i);
            step("t5_halt_all");
        end
        check("t5_all_off", {10'd0, all_off, issue_valid}, 12'b10);
        repeat (2) step("t5_idle");
        start_valid = 1'b1; start_tid = 2'd2;
        step("t5_start2");
        repeat (3) step("t5_single");

        // Async reset mid-stream with tid 1 stalled.
        start_valid = 1'b1; start_tid = 2'd1;
        step("t6_start1");
        stall_valid = 1'b1; stall_tid = 2'd1;
        step("t6_stall1");
        step("t6_run");
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_async", observed(), RESET_VEC);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_rst_hold", observed(), RESET_VEC);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t6_restart");
            check("t6_tid", {10'd0, issue_tid}, 12'(i % NT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
